// File: rtl/id_issue_ctrl_pkg.sv
// Shared constants, opcode map and types for the decode issue queue.
package id_issue_ctrl_pkg;

    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_W       = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } q_entry_t;

    // rs1 is read by everything except the upper-immediate and JAL forms
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    // rs2 is read only by register-register, store and branch forms
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Fetch-side, issue-side and EX-feedback signals of the issue queue.
interface id_issue_ctrl_if
    import id_issue_ctrl_pkg::*;
;
    logic                   if_valid;
    logic                   if_ready;
    logic [XLEN-1:0]        if_inst;
    logic [XLEN-1:0]        if_pc;
    logic                   id_valid;
    logic                   id_ready;
    logic [XLEN-1:0]        id_inst;
    logic [XLEN-1:0]        id_pc;
    logic [XLEN-1:0]        id_imm;
    logic                   ex_mem_read;
    logic [REG_W-1:0]       ex_rd;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // pipeline side: drives fetch offer, downstream ready and EX feedback
    modport master (
        output if_valid, if_inst, if_pc, id_ready, ex_mem_read, ex_rd, flush,
        input  if_ready, id_valid, id_inst, id_pc, id_imm, stall_cnt
    );

    // queue side
    modport slave (
        input  if_valid, if_inst, if_pc, id_ready, ex_mem_read, ex_rd, flush,
        output if_ready, id_valid, id_inst, id_pc, id_imm, stall_cnt
    );
endinterface

// File: rtl/id_issue_ctrl_imm_gen.sv
// Sign-extended immediate decode; unrecognised opcodes yield zero.
module id_issue_ctrl_imm_gen
    import id_issue_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] imm_c
);

    // Select immediate layout by opcode
    always_comb begin
        imm_c = '0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_c = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_c = {inst[31:12], 12'b0};
            OPC_JAL:
                imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm_c = '0;
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode issue queue: buffers fetched instructions, blocks the head on a
// load-use hazard against EX, and counts the resulting stall cycles.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    id_issue_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    occ_state_t             state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    q_entry_t               mem_q [DEPTH];
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    q_entry_t        head;
    logic [6:0]      head_opc;
    logic [REG_W-1:0] head_rs1, head_rs2;
    logic [XLEN-1:0] head_imm;
    logic            hazard;
    logic            if_ready;
    logic            id_valid;
    logic            push;
    logic            pop;

    assign head     = mem_q[rd_ptr_q];
    assign head_opc = head.inst[6:0];
    assign head_rs1 = head.inst[19:15];
    assign head_rs2 = head.inst[24:20];

    id_issue_ctrl_imm_gen u_imm_gen (
        .inst  (head.inst),
        .imm_c (head_imm)
    );

    // Load-use hazard of the head entry against the instruction in EX
    always_comb begin
        hazard = bus.ex_mem_read && (bus.ex_rd != '0) &&
                 ((uses_rs1(head_opc) && (head_rs1 == bus.ex_rd)) ||
                  (uses_rs2(head_opc) && (head_rs2 == bus.ex_rd)));
    end

    // Occupancy next-state, handshakes and count update; flush overrides all
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        if_ready = (state_q != OCC_FULL);
        id_valid = (state_q != OCC_EMPTY) && !hazard && !bus.flush;
        push     = bus.if_valid && if_ready && !bus.flush;
        pop      = id_valid && bus.id_ready;

        if (bus.flush) begin
            state_d = OCC_EMPTY;
            count_d = '0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end

            case (state_q)
                OCC_EMPTY: begin
                    if (push) state_d = OCC_PARTIAL;
                end
                OCC_PARTIAL: begin
                    if (count_d == CNT_W'(DEPTH)) begin
                        state_d = OCC_FULL;
                    end else if (count_d == '0) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) state_d = OCC_PARTIAL;
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // State, occupancy and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OCC_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Queue storage, cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {bus.if_inst, bus.if_pc};
        end
    end

    // Saturating count of cycles the head was held by a load-use hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q != OCC_EMPTY) && hazard && !bus.flush &&
                     (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign bus.if_ready  = if_ready;
    assign bus.id_valid  = id_valid;
    assign bus.id_inst   = head.inst;
    assign bus.id_pc     = head.pc;
    assign bus.id_imm    = head_imm;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed vector bench for id_issue_ctrl (DEPTH 2).
module tb_id_issue_ctrl;

    localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_LUI  = 32'h1234_52B7; // lui  x5,0x12345 (rs1 field = 8)
    localparam logic [31:0] I_SW   = 32'h0020_A423; // sw   x2,8(x1)
    localparam logic [31:0] I_LW   = 32'hFFF1_2203; // lw   x4,-1(x2)
    localparam logic [31:0] I_BEQ  = 32'hFE20_8EE3; // beq  x1,x2,-4
    localparam logic [31:0] I_UNK  = 32'h0000_007F; // unknown opcode

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        rdy;
        logic        mr;
        logic [4:0]  rd;
        logic        fl;
        logic        chkd;
        logic        e_ifr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_imm;
        logic [15:0] e_stall;
    } vec_t;

    localparam int NVEC = 29;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs [NVEC];

    id_issue_ctrl_if bus ();

    id_issue_ctrl #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic iv, input logic [31:0] inst, input logic [31:0] pc,
        input logic rdy, input logic mr, input logic [4:0] rd, input logic fl,
        input logic chkd, input logic e_ifr, input logic e_val,
        input logic [31:0] e_inst, input logic [31:0] e_pc,
        input logic [31:0] e_imm, input logic [15:0] e_stall);
        vec_t v;
        v.iv = iv; v.inst = inst; v.pc = pc; v.rdy = rdy; v.mr = mr;
        v.rd = rd; v.fl = fl; v.chkd = chkd; v.e_ifr = e_ifr; v.e_val = e_val;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_imm = e_imm; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] inst,
                         input logic [31:0] pc, input logic rdy, input logic mr,
                         input logic [4:0] rd, input logic fl);
        bus.if_valid    = iv;
        bus.if_inst     = inst;
        bus.if_pc       = pc;
        bus.id_ready    = rdy;
        bus.ex_mem_read = mr;
        bus.ex_rd       = rd;
        bus.flush       = fl;
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk("rst_if_ready", idx, 32'(bus.if_ready), 32'd1);
        chk("rst_id_valid", idx, 32'(bus.id_valid), 32'd0);
        chk("rst_id_inst",  idx, bus.id_inst, 32'd0);
        chk("rst_id_pc",    idx, bus.id_pc,   32'd0);
        chk("rst_id_imm",   idx, bus.id_imm,  32'd0);
        chk("rst_stall",    idx, 32'(bus.stall_cnt), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0, 1'b0);

        //           iv  inst    pc         rdy mr  rd  fl  chkd ifr val e_inst  e_pc       e_imm         stall
        vecs[0]  = mk(0, '0,     '0,        0,  0,  0,  0,  1,   1,  0,  '0,     '0,        '0,           0);
        vecs[1]  = mk(1, I_ADDI, 32'h100,   1,  0,  0,  0,  1,   1,  0,  '0,     '0,        '0,           0);
        vecs[2]  = mk(0, '0,     '0,        1,  0,  0,  0,  1,   1,  1,  I_ADDI, 32'h100,   32'h5,        0);
        vecs[3]  = mk(0, '0,     '0,        1,  0,  0,  0,  1,   1,  0,  '0,     '0,        '0,           0);
        vecs[4]  = mk(1, I_SW,   32'h104,   0,  0,  0,  0,  1,   1,  0,  '0,     '0,        '0,           0);
        vecs[5]  = mk(1, I_LW,   32'h108,   0,  0,  0,  0,  1,   1,  1,  I_SW,   32'h104,   32'h8,        0);
        vecs[6]  = mk(1, I_BEQ,  32'h10C,   0,  0,  0,  0,  1,   0,  1,  I_SW,   32'h104,   32'h8,        0);
        vecs[7]  = mk(1, I_BEQ,  32'h10C,   1,  0,  0,  0,  1,   0,  1,  I_SW,   32'h104,   32'h8,        0);
        vecs[8]  = mk(1, I_BEQ,  32'h10C,   1,  0,  0,  0,  1,   1,  1,  I_LW,   32'h108,   32'hFFFFFFFF, 0);
        vecs[9]  = mk(0, '0,     '0,        1,  1,  2,  0,  1,   1,  0,  I_BEQ,  32'h10C,   32'hFFFFFFFC, 0);
        vecs[10] = mk(0, '0,     '0,        0,  1,  0,  0,  1,   1,  1,  I_BEQ,  32'h10C,   32'hFFFFFFFC, 1);
        vecs[11] = mk(0, '0,     '0,        1,  0,  1,  0,  1,   1,  1,  I_BEQ,  32'h10C,   32'hFFFFFFFC, 1);
        vecs[12] = mk(1, I_ADD,  32'h200,   1,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           1);
        vecs[13] = mk(0, '0,     '0,        1,  1,  1,  0,  1,   1,  0,  I_ADD,  32'h200,   '0,           1);
        vecs[14] = mk(0, '0,     '0,        1,  0,  0,  0,  1,   1,  1,  I_ADD,  32'h200,   '0,           2);
        vecs[15] = mk(1, I_LUI,  32'h300,   0,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[16] = mk(0, '0,     '0,        0,  1,  8,  0,  1,   1,  1,  I_LUI,  32'h300,   32'h12345000, 2);
        vecs[17] = mk(0, '0,     '0,        1,  1,  0,  0,  1,   1,  1,  I_LUI,  32'h300,   32'h12345000, 2);
        vecs[18] = mk(1, I_ADDI, 32'h400,   0,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[19] = mk(1, I_ADD,  32'h404,   0,  0,  0,  0,  1,   1,  1,  I_ADDI, 32'h400,   32'h5,        2);
        vecs[20] = mk(1, I_LW,   32'h408,   1,  0,  0,  1,  1,   0,  0,  I_ADDI, 32'h400,   32'h5,        2);
        vecs[21] = mk(0, '0,     '0,        1,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[22] = mk(1, I_LW,   32'h500,   1,  0,  0,  1,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[23] = mk(0, '0,     '0,        1,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[24] = mk(1, I_ADD,  32'h600,   0,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[25] = mk(0, '0,     '0,        1,  1,  2,  1,  1,   1,  0,  I_ADD,  32'h600,   '0,           2);
        vecs[26] = mk(0, '0,     '0,        1,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[27] = mk(1, I_UNK,  32'h700,   0,  0,  0,  0,  0,   1,  0,  '0,     '0,        '0,           2);
        vecs[28] = mk(0, '0,     '0,        1,  0,  0,  0,  1,   1,  1,  I_UNK,  32'h700,   '0,           2);

        // Reset window, then release on a falling edge
        @(negedge clk);
        #2;
        chk_reset_outputs(0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven cycles: drive on falling edge, sample 2 units later
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].inst, vecs[i].pc, vecs[i].rdy,
                  vecs[i].mr, vecs[i].rd, vecs[i].fl);
            #2;
            chk("if_ready",  i, 32'(bus.if_ready),  32'(vecs[i].e_ifr));
            chk("id_valid",  i, 32'(bus.id_valid),  32'(vecs[i].e_val));
            chk("stall_cnt", i, 32'(bus.stall_cnt), 32'(vecs[i].e_stall));
            if (vecs[i].chkd) begin
                chk("id_inst", i, bus.id_inst, vecs[i].e_inst);
                chk("id_pc",   i, bus.id_pc,   vecs[i].e_pc);
                chk("id_imm",  i, bus.id_imm,  vecs[i].e_imm);
            end
        end

        // Fill the queue, then assert reset between edges
        @(negedge clk);
        drive(1'b1, I_ADDI, 32'h800, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, I_ADD, 32'h804, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        chk("pre_rst_valid", 100, 32'(bus.id_valid), 32'd1);
        chk("pre_rst_pc",    100, bus.id_pc, 32'h800);
        chk("pre_rst_stall", 100, 32'(bus.stall_cnt), 32'd2);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs(101);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            chk("post_rst_valid", 110 + k, 32'(bus.id_valid), 32'd0);
            chk("post_rst_ready", 110 + k, 32'(bus.if_ready), 32'd1);
        end

        // Stall counter saturation with a permanently blocked head
        @(negedge clk);
        drive(1'b1, I_ADD, 32'h900, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 5'd1, 1'b0);
        #2;
        chk("sat_blocked", 120, 32'(bus.id_valid), 32'd0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 121, 32'(bus.stall_cnt), 32'h0000FFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", 122, 32'(bus.stall_cnt), 32'h0000FFFF);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
        #2;
        chk("sat_release", 123, 32'(bus.id_valid), 32'd1);
        chk("sat_hold",    123, 32'(bus.stall_cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
